// File: rtl/approx_mul_pkg.sv
// Shared widths and correction-term bit positions for the 8x8 approximate multiplier.
package approx_mul_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int DROP_W = 4;   // low nibble of x whose partial products are truncated
  localparam int CBIT0  = 8;
  localparam int CBIT1  = 9;
  localparam int CBIT2  = 10;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

  function automatic prod_t bit_at(input logic b, input int pos);
    return prod_t'(b) << pos;
  endfunction
endpackage

// File: rtl/approx_mul8_l4.sv
// Combinational 8x8 multiplier: exact product, or truncated low-nibble product plus
// two small carry-compensation terms.
module approx_mul8_l4
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic              approx,
  output logic [PROD_W-1:0] z
);
  prod_t exact_p;
  prod_t trunc_p;
  prod_t c1;
  prod_t c2;

  always_comb begin
    exact_p = prod_t'(x) * prod_t'(y);
    trunc_p = (prod_t'(y) * prod_t'(x[OP_W-1:DROP_W])) << DROP_W;
    // Compensation for the dropped x[3:0] partial products' carries into bits 8..10
    c1 = bit_at((x[0] & y[7]) | (x[1] & y[6]), CBIT0)
       | bit_at((x[2] & y[6]) | (x[3] & y[5]), CBIT1)
       | bit_at(x[3] & y[7], CBIT2);
    c2 = bit_at(x[1] & y[7], CBIT0)
       | bit_at((x[2] & y[7]) | (x[3] & y[6]), CBIT1);
    z = approx ? (trunc_p + c1 + c2) : exact_p;
  end
endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiplier pipeline (S1 operands, S2 result)
// with valid/ready handshakes on both sides and per-mode result counters.
module approx_mul_arbiter
  import approx_mul_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_x,
  input  logic [NREQ*OP_W-1:0] req_y,
  input  logic [NREQ-1:0]      req_approx,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [PROD_W-1:0]    res_z,
  output logic [IDW-1:0]       res_id,
  output logic [15:0]          cnt_exact,
  output logic [15:0]          cnt_approx
);
  logic           run_q, run_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           s1_valid_q, s1_valid_d;
  op_t            s1_x_q, s1_x_d;
  op_t            s1_y_q, s1_y_d;
  logic           s1_approx_q, s1_approx_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;

  logic           s2_valid_q, s2_valid_d;
  prod_t          s2_z_q, s2_z_d;
  logic           s2_approx_q, s2_approx_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;

  logic [15:0]    cnt_exact_q, cnt_exact_d;
  logic [15:0]    cnt_approx_q, cnt_approx_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  int             idx;
  logic           s2_load;
  logic           s1_free;
  logic           accept;
  prod_t          mul_z;

  approx_mul8_l4 u_mul (
    .x      (s1_x_q),
    .y      (s1_y_q),
    .approx (s1_approx_q),
    .z      (mul_z)
  );

  // First valid requester at or after ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    s2_load   = !s2_valid_q || res_ready;
    s1_free   = !s1_valid_q || s2_load;
    // run_q keeps req_ready low until the first edge after reset release
    accept    = run_q && win_found && s1_free;
    req_ready = accept ? (NREQ'(1) << win_idx) : '0;

    run_d        = 1'b1;
    ptr_d        = ptr_q;
    s1_valid_d   = s1_valid_q && !s2_load;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s1_approx_d  = s1_approx_q;
    s1_id_d      = s1_id_q;
    s2_valid_d   = s2_valid_q;
    s2_z_d       = s2_z_q;
    s2_approx_d  = s2_approx_q;
    s2_id_d      = s2_id_q;
    cnt_exact_d  = cnt_exact_q;
    cnt_approx_d = cnt_approx_q;

    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_x_d      = req_x[int'(win_idx)*OP_W +: OP_W];
      s1_y_d      = req_y[int'(win_idx)*OP_W +: OP_W];
      s1_approx_d = req_approx[win_idx];
      s1_id_d     = win_idx;
      ptr_d       = (int'(win_idx) == NREQ-1) ? '0 : win_idx + 1'b1;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d      = mul_z;
        s2_approx_d = s1_approx_q;
        s2_id_d     = s1_id_q;
      end
    end

    if (s2_valid_q && res_ready) begin
      if (s2_approx_q) cnt_approx_d = cnt_approx_q + 16'd1;
      else             cnt_exact_d  = cnt_exact_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_approx_q  <= 1'b0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_z_q       <= '0;
      s2_approx_q  <= 1'b0;
      s2_id_q      <= '0;
      cnt_exact_q  <= '0;
      cnt_approx_q <= '0;
    end else begin
      run_q        <= run_d;
      ptr_q        <= ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_approx_q  <= s1_approx_d;
      s1_id_q      <= s1_id_d;
      s2_valid_q   <= s2_valid_d;
      s2_z_q       <= s2_z_d;
      s2_approx_q  <= s2_approx_d;
      s2_id_q      <= s2_id_d;
      cnt_exact_q  <= cnt_exact_d;
      cnt_approx_q <= cnt_approx_d;
    end
  end

  assign res_valid  = s2_valid_q;
  assign res_z      = s2_z_q;
  assign res_id     = s2_id_q;
  assign cnt_exact  = cnt_exact_q;
  assign cnt_approx = cnt_approx_q;
endmodule
